// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache. Lines hold four 16-bit words.
// A miss stalls the pipeline, writes back a dirty victim, then refills the line.
module dcache_wb #(
  parameter int unsigned IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic [13:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy
);

  localparam int unsigned Lines = 2 ** IDX_W;
  localparam int unsigned TagW  = 14 - IDX_W;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e            state_q, state_d;
  logic [Lines-1:0]  valid_q, valid_d;
  logic [Lines-1:0]  dirty_q, dirty_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [13:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;

  logic [TagW-1:0]   tag_q  [Lines];
  logic [63:0]       data_q [Lines];

  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [TagW-1:0]   tag;
  logic              req;
  logic              hit;
  logic [63:0]       line;
  logic              fill_en;
  logic              wr_hit;
  logic              stall_c;
  logic [15:0]       rdata_c;

  assign off  = addr[1:0];
  assign idx  = addr[IDX_W+1:2];
  assign tag  = addr[15:IDX_W+2];
  assign req  = re | we;
  assign line = data_q[idx];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_en     = 1'b0;
    wr_hit      = 1'b0;
    stall_c     = 1'b0;
    rdata_c     = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            if (we) begin
              wr_hit       = 1'b1;
              dirty_d[idx] = 1'b1;
            end else begin
              rdata_c = line[{off, 4'b0000} +: 16];
            end
          end else begin
            stall_c = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d     = StWriteback;
              mem_wr_d    = 1'b1;
              mem_addr_d  = {tag_q[idx], idx};
              mem_wdata_d = line;
            end else begin
              state_d    = StAllocate;
              mem_rd_d   = 1'b1;
              mem_addr_d = {tag, idx};
            end
          end
        end
      end
      StWriteback: begin
        stall_c = 1'b1;
        if (mem_rdy) begin
          state_d      = StAllocate;
          mem_wr_d     = 1'b0;
          mem_addr_d   = {tag, idx};
          dirty_d[idx] = 1'b0;
        end
      end
      StAllocate: begin
        stall_c = 1'b1;
        // After a writeback the bus idles one cycle so a lingering mem_rdy
        // cannot be taken as the fill response.
        if (!mem_rd_q) begin
          mem_rd_d = 1'b1;
        end else if (mem_rdy) begin
          state_d      = StIdle;
          mem_rd_d     = 1'b0;
          fill_en      = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx][{off, 4'b0000} +: 16] <= wdata;
    end
  end

  // A request held through reset must not keep the pipeline frozen.
  assign stall     = stall_c & rst_n;
  assign rdata     = rdata_c;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
